// File: rtl/clk_divider_pkg.sv
// clk_divider shared types, constants and phase-length helpers.
// Imported by clk_divider and clk_divider_mux.
package clk_divider_pkg;

  localparam int unsigned RATIO_WD_DEF = 3;

  // Ratios below this value select bypass
  localparam int unsigned BYPASS_THR = 2;

  // LOW phase gets the extra cycle for odd ratios
  function automatic int unsigned low_len(
    input int unsigned n
  );
    return (n + 1) >> 1;
  endfunction

  function automatic int unsigned high_len(
    input int unsigned n
  );
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_divider_mux.sv
// clk_divider output clock select: divided clock or reference clock.
// Kept separate so it can be replaced by a library clock-mux cell.
module clk_divider_mux
  import clk_divider_pkg::*;
(
  input  logic i_ref_clk,
  input  logic i_div_clk,
  input  logic i_sel_div,
  output logic o_clk
);

  // Plain combinational select, not glitch-free
  always_comb begin
    o_clk = i_sel_div ? i_div_clk : i_ref_clk;
  end

endmodule

// File: rtl/clk_divider.sv
// clk_divider: integer divider with reference-clock bypass.
// Optional macro CLKDIV_RATIO_SYNC_EN: ratio applied per full period.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned RATIO_WD = RATIO_WD_DEF
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk
);

  localparam int unsigned CNT_WD =
    (RATIO_WD > 2) ? RATIO_WD - 1 : 1;

  logic [RATIO_WD-1:0] ratio_eff;
  logic                active;
  logic                tog;
  int unsigned         phase_len;
  logic [CNT_WD-1:0]   cnt_d;
  logic [CNT_WD-1:0]   cnt_q;
  logic                div_d;
  logic                div_q;

`ifdef CLKDIV_RATIO_SYNC_EN
  logic [RATIO_WD-1:0] shd_d;
  logic [RATIO_WD-1:0] shd_q;
  logic                rld_d;
  logic                rld_q;
  logic                trk;

  // Shadow follows the input after reset, in bypass, or at period end
  always_comb begin
    trk = rld_q | ~i_clk_en
        | (32'(shd_q) < BYPASS_THR);
    ratio_eff = trk ? i_div_ratio : shd_q;
    shd_d = shd_q;
    rld_d = 1'b0;
    if (trk || (active && tog && div_q)) begin
      shd_d = i_div_ratio;
    end
  end

  // Shadow ratio and reload-after-reset flag
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      shd_q <= '0;
      rld_q <= 1'b1;
    end else begin
      shd_q <= shd_d;
      rld_q <= rld_d;
    end
  end
`else
  // Ratio input is used directly every cycle
  always_comb begin
    ratio_eff = i_div_ratio;
  end
`endif

  // Mode select and end-of-phase detect
  always_comb begin
    active = i_clk_en
           && (32'(ratio_eff) >= BYPASS_THR);
    phase_len = div_q ? high_len(32'(ratio_eff))
                      : low_len(32'(ratio_eff));
    tog = (32'(cnt_q) + 32'd1) >= phase_len;
  end

  // Count within a phase, toggle at its end, hold at 0 in bypass
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (!active) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (tog) begin
      cnt_d = '0;
      div_d = ~div_q;
    end else begin
      cnt_d = cnt_q + CNT_WD'(1);
    end
  end

  // Phase counter and divided clock
  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  clk_divider_mux u_mux (
    .i_ref_clk (i_ref_clk),
    .i_div_clk (div_q),
    .i_sel_div (active),
    .o_clk     (o_div_clk)
  );

endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: randomized check against a period/phase model.
// Model: output = (edges since start mod N) >= ceil(N/2).
module tb_clk_divider;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] ratio;
  logic       div_clk;

  int n_chk;
  int n_fail;
  int k;
  int ecnt;

  clk_divider #(.RATIO_WD(3)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always @(posedge div_clk) ecnt++;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int mval(input int kk, input int n);
    return ((kk % n) >= ((n + 1) / 2)) ? 1 : 0;
  endfunction

  // One reference cycle: check after each edge
  task automatic cycle(input bit act, input int n);
    @(posedge clk);
    if (act) k++;
    #1;
    chk("hi_half", int'(div_clk),
        act ? mval(k, n) : 1);
    @(negedge clk);
    #1;
    chk("lo_half", int'(div_clk),
        act ? mval(k, n) : 0);
  endtask

  // Pass through one bypass cycle, then run a segment
  task automatic seg(
    input bit e, input int n, input int cyc
  );
    bit act;
    en = 1'b0;
    ratio = 3'(n);
    #1;
    chk("byp_entry", int'(div_clk), 0);
    cycle(1'b0, n);
    act = e && (n >= 2);
    en = e;
    k = 0;
    #1;
    chk("seg_start", int'(div_clk), 0);
    for (int i = 0; i < cyc; i++) cycle(act, n);
  endtask

  bit mid_exp [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    ecnt = 0;
    rst = 1'b1;
    en = 1'b1;
    ratio = 3'd3;
    #1;
    chk("reset_out", int'(div_clk), 0);
    #4;
    rst = 1'b0;
    k = 0;
    ecnt = 0;
    for (int i = 0; i < 30; i++) cycle(1'b1, 3);
    chk("n3_periods", ecnt, 10);

    seg(1'b1, 4, 12);
    seg(1'b1, 0, 4);
    seg(1'b1, 1, 4);
    seg(1'b0, 6, 4);
    seg(1'b1, 6, 14);
    seg(1'b1, 7, 16);

    seg(1'b1, 6, 4);
    @(posedge clk);
    #2;
    chk("pre_rst_hi", int'(div_clk), 1);
    rst = 1'b1;
    #1;
    chk("rst_drop", int'(div_clk), 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 6);

`ifdef CLKDIV_RATIO_SYNC_EN
    mid_exp = '{1, 1, 1, 0, 0, 1, 0};
`else
    mid_exp = '{1, 0, 0, 1, 0, 0, 1};
`endif
    seg(1'b1, 6, 2);
    ratio = 3'd3;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("mid_change", int'(div_clk),
          int'(mid_exp[i]));
    end
    @(negedge clk);
    #1;

    for (int s = 0; s < 12; s++) begin
      bit e;
      int n;
      int c;
      e = ($urandom_range(3, 0) != 0);
      n = int'($urandom_range(7, 0));
      c = int'($urandom_range(25, 6));
      seg(e, n, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
